// File: rtl/edsac_order_sequencer.sv
// edsac_order_sequencer
// Main-control sequencer for the EDSAC order cycle. It fetches the order
// addressed by the sequence control tank (SCT), latches it into the order
// tank, waits DECODE_CYCLES for the order decoders to settle, then hands the
// order to the arithmetic unit. When the arithmetic unit finishes, the SCT
// either advances by one or takes the jump address.
//
// Optional single-step support is compiled in with `define EDSAC_SINGLE_STEP_EN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle pulse, leaves STOPPED
//   halt_req            level, stop once the order in flight completes
//   mem_req/mem_addr    fetch request and address (= SCT) to the store
//   mem_ack/order_in    store data valid strobe and order word
//   order_tank          latched order: [16:12] function, [10:1] address, [0] length
//   op_stop/op_jump     decoded Z order / E,G transfer
//   jump_cond           accumulator sign condition met for the current transfer
//   exec_valid          execute strobe to the arithmetic unit
//   exec_done           arithmetic unit finished the order
//   sct                 sequence control tank
//   running             high in every state except STOPPED
//   step_mode, step     (EDSAC_SINGLE_STEP_EN only) pause after each order,
//                       fetch the next one on a step pulse
module edsac_order_sequencer #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned START_ADDR    = 0,
  parameter int unsigned DECODE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
`ifdef EDSAC_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [16:0]       order_in,
  output logic [16:0]       order_tank,
  input  logic              op_stop,
  input  logic              op_jump,
  input  logic              jump_cond,
  output logic              exec_valid,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] sct,
  output logic              running
);

  localparam int unsigned ORDER_W = 17;
  localparam int unsigned DCNT_W  = (DECODE_CYCLES > 1) ? $clog2(DECODE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_STOPPED  = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXECUTE  = 3'd3,
    ST_ADVANCE  = 3'd4,
    ST_HALTED_Z = 3'd5
`ifdef EDSAC_SINGLE_STEP_EN
    , ST_PAUSED = 3'd6
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sct_q, sct_d;
  logic [ORDER_W-1:0]  tank_q, tank_d;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                exec_valid_q, exec_valid_d;
  logic                running_q, running_d;

  // State and datapath registers; outputs are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STOPPED;
      sct_q        <= ADDR_W'(START_ADDR);
      tank_q       <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      exec_valid_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sct_q        <= sct_d;
      tank_q       <= tank_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      exec_valid_q <= exec_valid_d;
      running_q    <= running_d;
    end
  end

  // Next-state, SCT update, order latch and decode timer
  always_comb begin
    state_d = state_q;
    sct_d   = sct_q;
    tank_d  = tank_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_STOPPED: begin
        // start wins over a simultaneous halt_req
        if (start) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (mem_ack) begin
          tank_d  = order_in;
          cnt_d   = DCNT_W'(DECODE_CYCLES - 1);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (cnt_q == '0) begin
          state_d = op_stop ? ST_HALTED_Z : ST_EXECUTE;
        end else begin
          cnt_d = cnt_q - DCNT_W'(1);
        end
      end

      ST_EXECUTE: begin
        if (exec_done) state_d = ST_ADVANCE;
      end

      ST_ADVANCE: begin
        if (op_jump && jump_cond) begin
          sct_d = tank_q[ADDR_W:1];
        end else begin
          sct_d = sct_q + ADDR_W'(1);
        end
        if (halt_req) begin
          state_d = ST_STOPPED;
        end
`ifdef EDSAC_SINGLE_STEP_EN
        else if (step_mode) begin
          state_d = ST_PAUSED;
        end
`endif
        else begin
          state_d = ST_FETCH;
        end
      end

      ST_HALTED_Z: begin
        // Resume after a Z order continues at the following order
        sct_d   = sct_q + ADDR_W'(1);
        state_d = ST_STOPPED;
      end

`ifdef EDSAC_SINGLE_STEP_EN
      ST_PAUSED: begin
        if (halt_req) begin
          state_d = ST_STOPPED;
        end else if (step) begin
          state_d = ST_FETCH;
        end
      end
`endif

      default: begin
        state_d = ST_STOPPED;
      end
    endcase

    mem_req_d    = (state_d == ST_FETCH);
    exec_valid_d = (state_d == ST_EXECUTE);
    running_d    = (state_d != ST_STOPPED);
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = sct_q;
  assign order_tank = tank_q;
  assign exec_valid = exec_valid_q;
  assign sct        = sct_q;
  assign running    = running_q;

endmodule

// File: doc/edsac_order_sequencer.md
Name: edsac_order_sequencer

Overview:
- Main-control sequencer for the EDSAC order cycle.
- Fetches the order addressed by the sequence control tank (SCT) from the store and latches it into the order tank. The order tank's function bits feed the order decoders.
- Waits for the decoded order to execute, then advances or jumps the SCT.
- Sits between the store interface, the order decoders and the arithmetic unit.

Parameters:
- ADDR_W, 10, store address width; also the width of the SCT and of the order address field.
- START_ADDR, 0, SCT value after reset (initial orders location).
- DECODE_CYCLES, 2, clocks spent in DECODE so the decoder outputs settle; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; leaves STOPPED
- halt_req  in  1  level; stop after the current order completes
- mem_req  out  1  fetch request to the store
- mem_addr  out  ADDR_W  fetch address (= SCT)
- mem_ack  in  1  store has valid data on order_in this cycle
- order_in  in  17  order word from the store
- order_tank  out  17  latched order; bits [16:12] function, [10:1] address, [0] length
- op_stop  in  1  decoder: Z order
- op_jump  in  1  decoder: E/G conditional transfer
- jump_cond  in  1  accumulator sign condition satisfied for the current jump
- exec_valid  out  1  execute strobe to the arithmetic unit
- exec_done  in  1  arithmetic unit finished the order
- sct  out  ADDR_W  sequence control tank
- running  out  1  high in every state except STOPPED

Behaviour:
- Reset (async, rst_n low) forces:
  - state = STOPPED
  - sct = START_ADDR
  - order_tank = 0
  - mem_req = 0, exec_valid = 0, running = 0
  - decode counter = 0
- States:
  - STOPPED: start=1 -> FETCH. Otherwise hold.
  - FETCH: mem_req=1, mem_addr=sct. When mem_ack=1 (may be the first FETCH cycle): order_tank <= order_in, load decode counter with DECODE_CYCLES-1, go to DECODE. mem_req stays high until ack; no timeout.
  - DECODE: count down. At counter==0:
    - op_stop=1 -> HALTED_Z
    - else -> EXECUTE
  - EXECUTE: exec_valid=1 every cycle in this state. exec_done sampled high -> ADVANCE. exec_valid drops the cycle after exec_done. exec_done high on the first EXECUTE cycle is legal (one-cycle execute).
  - ADVANCE (one cycle):
    - op_jump & jump_cond -> sct <= order_tank[10:1]
    - else sct <= sct+1, wrapping modulo 2^ADDR_W (all-ones -> 0)
    - Then: halt_req=1 -> STOPPED, else -> FETCH.
  - HALTED_Z: sct <= sct+1 (resume continues at the next order), then STOPPED on the next cycle.
- order_tank changes only in FETCH on mem_ack; the decoder inputs are stable from DECODE through ADVANCE.
- start while running: ignored.
- halt_req while running: sampled only in ADVANCE; the order in flight always completes.
- start and halt_req together in STOPPED: start wins; halt is re-sampled at the next ADVANCE.
- Reset mid-fetch or mid-execute: mem_req and exec_valid drop asynchronously; no partial SCT update.
- Fetch-to-fetch latency with immediate ack and exec_done: 1 (FETCH) + DECODE_CYCLES + 1 (EXECUTE) + 1 (ADVANCE) clocks.

Optional Feature:
- Macro: EDSAC_SINGLE_STEP_EN.
- Defined:
  - Adds input step_mode (1 bit) and input step (1-cycle pulse).
  - With step_mode=1, ADVANCE goes to PAUSED instead of FETCH.
  - PAUSED: running=1, no requests issued. step=1 -> FETCH. halt_req=1 -> STOPPED; halt_req has priority over step.
  - step_mode=0 behaves exactly as without the macro.
- Undefined: no step ports, no PAUSED state; ADVANCE always goes to FETCH or STOPPED.

Test Plan:
- Reset then start; store acks immediately with order_in=0x00000 (no stop, no jump), exec_done after 1 cycle -> mem_addr sequence 0,1,2; one fetch every 5 clocks with DECODE_CYCLES=2.
- Fetch at sct=5 with order_in=17'h0_0064 (address field 0x032), op_jump=1, jump_cond=1 -> next mem_addr=0x032. Same order with jump_cond=0 -> next mem_addr=6.
- op_stop=1 at sct=0x3FF -> running falls 2 clocks after DECODE ends, sct=0x000. Then start -> fetch from 0x000.
- mem_ack delayed 7 cycles and exec_done delayed 20 cycles -> mem_req held for exactly 8 cycles, exec_valid for exactly 21 cycles, order_tank unchanged during EXECUTE.
- halt_req asserted mid-EXECUTE -> order completes, sct increments once, STOPPED with no further mem_req. Same cycle as start in STOPPED -> machine starts.
- rst_n pulsed low during FETCH with mem_req=1 -> mem_req=0 within the same cycle, sct=START_ADDR, state STOPPED. With EDSAC_SINGLE_STEP_EN and step_mode=1 -> exactly one fetch per step pulse.
